// File: rtl/axis_pkt_gen_pkg.sv
// Shared definitions for the AXI-Stream packet generator: FSM encoding
// and default bus widths.
package axis_pkt_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_LEN_W  = 8;

endpackage

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: on start, emits pkt_len beats of an
// incrementing data pattern beginning at seed, honouring m_ready backpressure.
module axis_pkt_gen
    import axis_pkt_gen_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int LEN_W  = DEFAULT_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  pkt_len,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       pkt_count
);

    state_t            state_q;
    logic [DATA_W-1:0] data_q;
    logic [LEN_W-1:0]  rem_q;    // beats still to send after the one on the bus
    logic              valid_q;
    logic              last_q;
    logic              done_q;
    logic [15:0]       count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && (pkt_len != '0)) begin
                        state_q <= SEND;
                        data_q  <= seed;
                        rem_q   <= pkt_len - 1'b1;
                        valid_q <= 1'b1;
                        last_q  <= (pkt_len == LEN_W'(1));
                    end
                end
                SEND: begin
                    if (valid_q && m_ready) begin
                        if (last_q) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                            count_q <= count_q + 16'd1;
                        end else begin
                            // Next beat is the last when only one remains after it.
                            data_q <= data_q + 1'b1;
                            rem_q  <= rem_q - 1'b1;
                            last_q <= (rem_q == LEN_W'(1));
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_data    = data_q;
    assign m_valid   = valid_q;
    assign m_last    = last_q;
    assign busy      = (state_q == SEND);
    assign done      = done_q;
    assign pkt_count = count_q;

endmodule

// File: doc/axis_pkt_gen.md
AXIS_PKT_GEN -- requirements
Module: axis_pkt_gen

Interface
REQ-001 Parameter DATA_W, default 8, sets the width of the stream data bus.
REQ-002 Parameter LEN_W, default 8, sets the width of the packet-length input and the beat counter.
REQ-003 Port clk  input  1  is the single clock; all logic samples on its rising edge.
REQ-004 Port reset  input  1  is the synchronous, active-high reset.
REQ-005 Port start  input  1  is a one-cycle request to begin a packet; it is sampled only in IDLE.
REQ-006 Port pkt_len  input  LEN_W  is the number of beats in the packet; it is latched on an accepted start.
REQ-007 Port seed  input  DATA_W  is the data value of the first beat; it is latched on an accepted start.
REQ-008 Port m_data  output  DATA_W  is the stream data.
REQ-009 Port m_valid  output  1  is the stream valid.
REQ-010 Port m_last  output  1  marks the final beat of the packet.
REQ-011 Port m_ready  input  1  is the downstream ready (backpressure).
REQ-012 Port busy  output  1  is high while a packet is in progress (state SEND).
REQ-013 Port done  output  1  is a one-cycle pulse after the last beat transfers.
REQ-014 Port pkt_count  output  16  is the number of packets completed since reset; it wraps modulo 2^16.

Function
REQ-015 FSM states: IDLE and SEND; the block SHALL hold no other state.
REQ-016 IDLE->SEND when start=1 and pkt_len!=0: latch len=pkt_len and data=seed; m_valid=1 and busy=1 from the next cycle.
REQ-017 start=1 with pkt_len=0 SHALL be ignored: the block stays in IDLE, no beat is sent, and done stays 0.
REQ-018 start SHALL be ignored while in SEND, and changes to pkt_len/seed in SEND SHALL have no effect.
REQ-019 A beat transfers on a cycle where m_valid=1 and m_ready=1; otherwise m_data, m_last and m_valid SHALL hold their values.
REQ-020 m_valid SHALL be a registered output and SHALL NOT depend combinationally on m_ready.
REQ-021 Beat i (0-based) SHALL carry m_data = (seed + i) mod 2^DATA_W; the data counter wraps, e.g. 8'hFF -> 8'h00.
REQ-022 m_last=1 exactly on beat len-1; when len=1 it is set on the first beat.
REQ-023 When the last beat transfers at cycle K, at cycle K+1: m_valid=0, m_last=0, busy=0, done=1, pkt_count+1, and the state is IDLE.
REQ-024 done SHALL be 1 for exactly one cycle per packet; a start in that cycle SHALL be accepted (state IDLE).
REQ-025 Minimum gap between packets: one idle cycle (m_valid=0) after every last beat.
REQ-026 pkt_len = 2^LEN_W-1 (max) SHALL send 255 beats at the defaults without counter overflow.
REQ-027 Continuous m_ready=1 SHALL give one beat per cycle with no bubbles inside a packet.

Reset
REQ-028 reset=1 at any rising edge, including mid-packet, SHALL force IDLE on the next cycle with m_data=0, m_valid=0, m_last=0, busy=0, done=0 and pkt_count=0.
REQ-029 A packet interrupted by reset SHALL NOT be counted and SHALL NOT generate done.

Structure
REQ-030 A shared package SHALL hold the state encoding (IDLE=0, SEND=1) and the default DATA_W/LEN_W constants.
REQ-031 The block SHALL be a single module with no sub-module; the beat and data counters are inline.

Verification
REQ-032 start, pkt_len=4, seed=8'h10, m_ready=1 -> data 10,11,12,13 on consecutive cycles, m_last on 13, done on the next cycle, pkt_count=1.
REQ-033 pkt_len=3, seed=8'hFE, m_ready toggled 1,0,0,1,0,1 -> beats FE,FF,00 in order; data/last held stable while m_ready=0; exactly 3 handshakes.
REQ-034 pkt_len=1, seed=8'hA5 -> a single beat A5 with m_last=1; done on the next cycle.
REQ-035 start with pkt_len=0 -> m_valid, busy and done stay 0 and pkt_count is unchanged; start pulsed mid-packet -> ignored, and the packet length is unchanged.
REQ-036 reset asserted during beat 2 of an 8-beat packet -> all outputs at reset values on the next cycle, pkt_count=0, no done; a new start afterwards works normally.
REQ-037 start asserted in the done cycle, two packets back-to-back of length 2 -> a one-cycle m_valid gap between them, and pkt_count=2.
